// File: rtl/wb_gpio_irq_if.sv
// Wishbone slave bus bundle for the GPIO peripheral: address, data both ways,
// write qualifier, cycle request and acknowledge.
interface wb_gpio_irq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
);
  logic [ADDR_WIDTH-1:0] adr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  we_i;
  logic                  stb_i;
  logic                  ack_o;

  modport master (
    output adr_i, dat_i, we_i, stb_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  adr_i, dat_i, we_i, stb_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO: output port with set/clear aliases, synchronised and
// debounced input port, per-bit edge detection into W1C pending flags, level irq.
module wb_gpio_irq #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 15,
  parameter int          OUT_BITS   = 4,
  parameter int          IN_BITS    = 2,
  parameter logic [15:0] DEB_DIV    = 16'd0
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_gpio_irq_if.slave        bus,
  output logic [OUT_BITS-1:0] gp_o,
  input  logic [IN_BITS-1:0]  gp_i,
  output logic                irq
);

  localparam logic [2:0] A_OUT     = 3'd0;
  localparam logic [2:0] A_OUT_SET = 3'd1;
  localparam logic [2:0] A_OUT_CLR = 3'd2;
  localparam logic [2:0] A_IN      = 3'd3;
  localparam logic [2:0] A_RISE_EN = 3'd4;
  localparam logic [2:0] A_FALL_EN = 3'd5;
  localparam logic [2:0] A_PENDING = 3'd6;
  localparam logic [2:0] A_DIV     = 3'd7;

  logic [2:0]            sel;
  logic                  acc;
  logic                  wr;
  logic [OUT_BITS-1:0]   out_q;
  logic [IN_BITS-1:0]    rise_en_q;
  logic [IN_BITS-1:0]    fall_en_q;
  logic [IN_BITS-1:0]    pend_q;
  logic [IN_BITS-1:0]    s1_q;
  logic [IN_BITS-1:0]    s2_q;
  logic [IN_BITS-1:0]    smp_q;
  logic [IN_BITS-1:0]    filt_q;
  logic [15:0]           div_q;
  logic [15:0]           cnt_q;
  logic                  tick;
  logic [IN_BITS-1:0]    upd;
  logic [IN_BITS-1:0]    filt_nxt;
  logic [IN_BITS-1:0]    edge_set;
  logic [IN_BITS-1:0]    w1c;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_bits;

  // Handshake: an access is accepted on a rising edge where stb_i=1 and
  // ack_o=0; that edge commits the write (or loads dat_o) and raises ack_o
  // for exactly one cycle, so a held stb_i yields one access per two cycles.
  assign sel = bus.adr_i[2:0];
  assign acc = bus.stb_i & ~bus.ack_o;
  assign wr  = acc & bus.we_i;

  assign unused_bits = ^{bus.adr_i, bus.dat_i};
  assign gp_o        = out_q;

  always_comb begin
    tick     = (cnt_q == 16'd0);
    // filt follows s2 only when two consecutive tick samples agree
    upd      = {IN_BITS{tick}} & ~(s2_q ^ smp_q);
    filt_nxt = (filt_q & ~upd) | (s2_q & upd);
    edge_set = (filt_nxt & ~filt_q & rise_en_q) | (~filt_nxt & filt_q & fall_en_q);
    w1c      = (wr && sel == A_PENDING) ? bus.dat_i[IN_BITS-1:0] : '0;
  end

  always_comb begin
    rd_data = '0;
    case (sel)
      A_OUT, A_OUT_SET, A_OUT_CLR: rd_data[OUT_BITS-1:0] = out_q;
      A_IN:                        rd_data[IN_BITS-1:0]  = filt_q;
      A_RISE_EN:                   rd_data[IN_BITS-1:0]  = rise_en_q;
      A_FALL_EN:                   rd_data[IN_BITS-1:0]  = fall_en_q;
      A_PENDING:                   rd_data[IN_BITS-1:0]  = pend_q;
      A_DIV:                       rd_data[15:0]         = div_q;
      default:                     rd_data               = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.ack_o <= 1'b0;
      bus.dat_o <= '0;
      irq       <= 1'b0;
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      div_q     <= DEB_DIV;
      cnt_q     <= DEB_DIV;
      s1_q      <= '0;
      s2_q      <= '0;
      smp_q     <= '0;
      filt_q    <= '0;
    end else begin
      bus.ack_o <= acc;
      if (acc && !bus.we_i) bus.dat_o <= rd_data;

      s1_q   <= gp_i;
      s2_q   <= s1_q;
      if (tick) smp_q <= s2_q;
      filt_q <= filt_nxt;

      // an edge arriving with a W1C of the same bit keeps the bit set
      pend_q <= (pend_q & ~w1c) | edge_set;
      irq    <= |pend_q;

      if (wr && sel == A_DIV) cnt_q <= bus.dat_i[15:0];
      else if (tick)          cnt_q <= div_q;
      else                    cnt_q <= cnt_q - 16'd1;

      if (wr) begin
        case (sel)
          A_OUT:     out_q     <= bus.dat_i[OUT_BITS-1:0];
          A_OUT_SET: out_q     <= out_q | bus.dat_i[OUT_BITS-1:0];
          A_OUT_CLR: out_q     <= out_q & ~bus.dat_i[OUT_BITS-1:0];
          A_RISE_EN: rise_en_q <= bus.dat_i[IN_BITS-1:0];
          A_FALL_EN: fall_en_q <= bus.dat_i[IN_BITS-1:0];
          A_DIV:     div_q     <= bus.dat_i[15:0];
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Bench for wb_gpio_irq: register table, directed multi-cycle corner cases and
// a randomized phase checked cycle by cycle against a behavioural model.
module tb_wb_gpio_irq;

  localparam logic [15:0] DEB_DIV = 16'd0;

  logic       clk;
  logic       rst_n;
  logic [3:0] gp_o;
  logic [1:0] gp_i;
  logic       irq;

  wb_gpio_irq_if #(.DATA_WIDTH(32), .ADDR_WIDTH(15)) bus ();

  wb_gpio_irq #(
    .DATA_WIDTH(32), .ADDR_WIDTH(15), .OUT_BITS(4), .IN_BITS(2), .DEB_DIV(DEB_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .gp_o(gp_o), .gp_i(gp_i), .irq(irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic model_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Valid while the divider is 0: the filtered input takes the pin value seen
  // 2 and 3 edges ago whenever those two samples agree.
  logic [3:0]  out_m;
  logic [1:0]  ren_m, fen_m, pend_m, filt_m, nf, set_b, clr_b;
  logic [1:0]  h1, h2, h3, h4;
  logic [15:0] div_m;
  logic        ack_m, irq_m, acc_m;
  logic [31:0] dat_m;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] reg_value(input logic [2:0] a);
    case (a)
      3'd0, 3'd1, 3'd2: return {28'd0, out_m};
      3'd3:             return {30'd0, filt_m};
      3'd4:             return {30'd0, ren_m};
      3'd5:             return {30'd0, fen_m};
      3'd6:             return {30'd0, pend_m};
      default:          return {16'd0, div_m};
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      out_m = '0; ren_m = '0; fen_m = '0; pend_m = '0; filt_m = '0;
      h1 = '0; h2 = '0; h3 = '0; h4 = '0;
      div_m = DEB_DIV; ack_m = 1'b0; irq_m = 1'b0; dat_m = '0;
    end else begin
      acc_m = bus.stb_i && !ack_m;
      irq_m = |pend_m;
      if (acc_m && !bus.we_i) dat_m = reg_value(bus.adr_i[2:0]);
      h4 = h3; h3 = h2; h2 = h1; h1 = gp_i;
      for (int b = 0; b < 2; b++) nf[b] = (h3[b] == h4[b]) ? h3[b] : filt_m[b];
      set_b  = (nf & ~filt_m & ren_m) | (~nf & filt_m & fen_m);
      clr_b  = (acc_m && bus.we_i && bus.adr_i[2:0] == 3'd6) ? bus.dat_i[1:0] : 2'b00;
      pend_m = (pend_m & ~clr_b) | set_b;
      filt_m = nf;
      if (acc_m && bus.we_i) begin
        case (bus.adr_i[2:0])
          3'd0: out_m = bus.dat_i[3:0];
          3'd1: out_m = out_m | bus.dat_i[3:0];
          3'd2: out_m = out_m & ~bus.dat_i[3:0];
          3'd4: ren_m = bus.dat_i[1:0];
          3'd5: fen_m = bus.dat_i[1:0];
          3'd7: div_m = bus.dat_i[15:0];
          default: ;
        endcase
      end
      ack_m = acc_m;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("model_irq",  {31'd0, irq},   {31'd0, irq_m});
      check("model_gp_o", {28'd0, gp_o},  {28'd0, out_m});
      check("model_ack",  {31'd0, bus.ack_o}, {31'd0, ack_m});
      check("model_dat",  bus.dat_o, dat_m);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_access(input logic we, input logic [2:0] adr, input logic [31:0] wd,
                           output logic [31:0] rd);
    int lat;
    bus.adr_i = {12'd0, adr};
    bus.dat_i = wd;
    bus.we_i  = we;
    bus.stb_i = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.ack_o && lat < 8);
    check("ack_lat", lat, 1);
    rd = bus.dat_o;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    tick_n(1);
    check("ack_drop", {31'd0, bus.ack_o}, 32'd0);
  endtask

  task automatic wb_read_check(input string name, input logic [2:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    wb_access(1'b0, adr, 32'd0, rd);
    exp_q.push_back(exp);
    check(name, rd, exp_q.pop_front());
  endtask

  // ---------------- register table ----------------
  typedef struct {
    logic        we;
    logic [2:0]  adr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [3:0]  exp_gp;
  } vec_t;
  vec_t vecs[$];

  function automatic void add_vec(input logic we, input logic [2:0] adr, input logic [31:0] wd,
                                  input logic [31:0] exp_rd, input logic [3:0] exp_gp);
    vec_t v;
    v.we = we; v.adr = adr; v.wd = wd; v.exp_rd = exp_rd; v.exp_gp = exp_gp;
    vecs.push_back(v);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd;
    logic [2:0]  ra;
    logic        rw;

    rst_n = 1'b0;
    gp_i  = 2'b00;
    bus.adr_i = '0; bus.dat_i = '0; bus.we_i = 1'b0; bus.stb_i = 1'b0;

    add_vec(0, 3'd0, 0, 32'h0, 4'h0);
    add_vec(0, 3'd1, 0, 32'h0, 4'h0);
    add_vec(0, 3'd2, 0, 32'h0, 4'h0);
    add_vec(0, 3'd3, 0, 32'h0, 4'h0);
    add_vec(0, 3'd4, 0, 32'h0, 4'h0);
    add_vec(0, 3'd5, 0, 32'h0, 4'h0);
    add_vec(0, 3'd6, 0, 32'h0, 4'h0);
    add_vec(0, 3'd7, 0, {16'd0, DEB_DIV}, 4'h0);
    add_vec(1, 3'd0, 32'hA, 0, 4'hA);
    add_vec(1, 3'd1, 32'h1, 0, 4'hB);
    add_vec(1, 3'd2, 32'h8, 0, 4'h3);
    add_vec(0, 3'd1, 0, 32'h3, 4'h3);
    add_vec(0, 3'd0, 0, 32'h3, 4'h3);
    add_vec(0, 3'd2, 0, 32'h3, 4'h3);
    add_vec(1, 3'd3, 32'hF, 0, 4'h3);
    add_vec(0, 3'd3, 0, 32'h0, 4'h3);
    add_vec(1, 3'd4, 32'hFF, 0, 4'h3);
    add_vec(0, 3'd4, 0, 32'h3, 4'h3);
    add_vec(1, 3'd5, 32'h2, 0, 4'h3);
    add_vec(0, 3'd5, 0, 32'h2, 4'h3);
    add_vec(1, 3'd7, 32'h12345, 0, 4'h3);
    add_vec(0, 3'd7, 0, 32'h2345, 4'h3);
    add_vec(1, 3'd7, 32'h0, 0, 4'h3);
    add_vec(0, 3'd7, 0, 32'h0, 4'h3);
    add_vec(1, 3'd0, 32'hFFFFFFFF, 0, 4'hF);
    add_vec(0, 3'd0, 0, 32'hF, 4'hF);
    add_vec(1, 3'd0, 32'h0, 0, 4'h0);

    tick_n(3);
    rst_n = 1'b1;
    check("rst_ack",  {31'd0, bus.ack_o}, 32'd0);
    check("rst_dat",  bus.dat_o, 32'd0);
    check("rst_gp_o", {28'd0, gp_o}, 32'd0);
    check("rst_irq",  {31'd0, irq}, 32'd0);
    model_on = 1'b1;

    foreach (vecs[i]) begin
      wb_access(vecs[i].we, vecs[i].adr, vecs[i].wd, rd);
      if (!vecs[i].we) check($sformatf("tbl_rd%0d", i), rd, vecs[i].exp_rd);
      check($sformatf("tbl_gp%0d", i), {28'd0, gp_o}, {28'd0, vecs[i].exp_gp});
    end

    // rising edge on bit 0 with DIV=0: irq rises 4 edges after the first capture edge
    wb_access(1, 3'd4, 32'h1, rd);
    wb_access(1, 3'd5, 32'h0, rd);
    gp_i = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      tick_n(1);
      check($sformatf("edge_irq_low%0d", i), {31'd0, irq}, 32'd0);
    end
    tick_n(1);
    check("edge_irq_high", {31'd0, irq}, 32'd1);
    wb_read_check("edge_in", 3'd3, 32'h1);
    wb_read_check("edge_pend", 3'd6, 32'h1);
    wb_access(1, 3'd6, 32'h1, rd);
    check("w1c_irq_low", {31'd0, irq}, 32'd0);
    wb_read_check("w1c_pend", 3'd6, 32'h0);

    // rising edge lands on the same edge as a W1C of that bit
    gp_i = 2'b00;
    tick_n(8);
    gp_i = 2'b01;
    tick_n(3);
    wb_access(1, 3'd6, 32'h1, rd);
    check("setwins_irq", {31'd0, irq}, 32'd1);
    wb_read_check("setwins_pend", 3'd6, 32'h1);
    tick_n(2);
    check("setwins_irq_hold", {31'd0, irq}, 32'd1);

    // randomized phase, divider held at 0
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 1) == 1) gp_i = 2'($urandom_range(0, 3));
      tick_n($urandom_range(0, 2));
      ra = 3'($urandom_range(0, 7));
      rw = (ra == 3'd7) ? 1'b0 : 1'($urandom_range(0, 1));
      wb_access(rw, ra, $urandom, rd);
    end

    // debounce with DIV=3
    gp_i = 2'b00;
    tick_n(10);
    model_on = 1'b0;
    wb_access(1, 3'd7, 32'h3, rd);
    wb_access(1, 3'd4, 32'h2, rd);
    wb_access(1, 3'd5, 32'h2, rd);
    tick_n(20);
    wb_access(1, 3'd6, 32'h3, rd);
    wb_read_check("deb_pend_clear", 3'd6, 32'h0);
    gp_i = 2'b10;
    tick_n(3);
    gp_i = 2'b00;
    tick_n(20);
    wb_read_check("deb_glitch_in", 3'd3, 32'h0);
    wb_read_check("deb_glitch_pend", 3'd6, 32'h0);
    gp_i = 2'b10;
    tick_n(12);
    gp_i = 2'b00;
    tick_n(20);
    wb_read_check("deb_pulse_pend", 3'd6, 32'h2);
    wb_read_check("deb_pulse_in", 3'd3, 32'h0);
    check("deb_pulse_irq", {31'd0, irq}, 32'd1);

    // reset during a held write
    wb_access(1, 3'd0, 32'h5, rd);
    check("pre_rst_gp", {28'd0, gp_o}, 32'h5);
    bus.adr_i = '0; bus.dat_i = 32'hC; bus.we_i = 1'b1; bus.stb_i = 1'b1;
    rst_n = 1'b0;
    tick_n(1);
    check("midrst_ack", {31'd0, bus.ack_o}, 32'd0);
    check("midrst_gp",  {28'd0, gp_o}, 32'd0);
    rst_n = 1'b1;
    tick_n(1);
    check("reissue_ack", {31'd0, bus.ack_o}, 32'd1);
    check("reissue_gp",  {28'd0, gp_o}, 32'hC);
    bus.stb_i = 1'b0; bus.we_i = 1'b0;
    tick_n(1);
    check("reissue_ack_drop", {31'd0, bus.ack_o}, 32'd0);
    wb_read_check("reissue_div", 3'd7, {16'd0, DEB_DIV});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
